// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard/stall logic of the 5-stage MIPS core.
package hazard_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int MDU_LATENCY_DEFAULT = 4;
    localparam int MDU_CNT_W = 4;

    typedef logic [MDU_CNT_W-1:0] mduCnt_t;

    typedef enum logic [1:0] {
        CTRL_RUN,
        CTRL_STALL,
        CTRL_FLUSH
    } ctrlAction_e;

    // A source register only conflicts when it is a real register, not $zero.
    function automatic logic regHit(input logic [4:0] dest, input logic [4:0] src);
        return (dest != REG_ZERO) && (dest == src);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID/EX-side signal bundle between the pipeline datapath (master) and the hazard unit (slave).
interface hazard_stall_unit_if;
    import hazard_pkg::*;

    logic [4:0] Rs_ID;
    logic [4:0] Rt_ID;
    logic       UsesRt_ID;
    logic       MduOp_ID;
    logic       MemRead_EX;
    logic [4:0] WriteReg_EX;
    logic       MduStart_EX;
    logic       BranchTaken_EX;

    logic       PCWrite;
    logic       IFID_Write;
    logic       IFID_Flush;
    logic       IDEX_Flush;
    logic       MduBusy;

    modport master (
        output Rs_ID, Rt_ID, UsesRt_ID, MduOp_ID, MemRead_EX, WriteReg_EX,
               MduStart_EX, BranchTaken_EX,
        input  PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, MduBusy
    );

    modport slave (
        input  Rs_ID, Rt_ID, UsesRt_ID, MduOp_ID, MemRead_EX, WriteReg_EX,
               MduStart_EX, BranchTaken_EX,
        output PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, MduBusy
    );

endinterface

// File: rtl/mdu_busy_counter.sv
// Tracks how long the multi-cycle mult/div unit is still busy after an issue.
module mdu_busy_counter
    import hazard_pkg::*;
#(
    parameter int LATENCY = MDU_LATENCY_DEFAULT
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    load,
    output logic    busy,
    output mduCnt_t count
);

    localparam mduCnt_t LOAD_VALUE = mduCnt_t'(LATENCY);

    // Reload on issue (also restarts an in-flight count); otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VALUE;
        end else if (count != '0) begin
            count <= count - mduCnt_t'(1);
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / taken-branch / MDU-busy hazard unit driving PC, IF/ID and ID/EX controls.
// Optional performance counters are compiled in with `define HAZARD_PERF_CNT_EN.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int MDU_LATENCY = MDU_LATENCY_DEFAULT,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_stall_unit_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    StallCycles,
    output logic [CNT_W-1:0]    FlushCount
`endif
);

    logic        loadUse;
    logic        mduStall;
    logic        stall;
    logic        mduBusy;
    mduCnt_t     mduCnt;
    ctrlAction_e action;

    // The mult/div in EX belongs to an instruction older than the branch, so it issues regardless.
    mdu_busy_counter #(
        .LATENCY (MDU_LATENCY)
    ) uMduBusy (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (hz.MduStart_EX),
        .busy  (mduBusy),
        .count (mduCnt)
    );

    always_comb begin
        loadUse  = hz.MemRead_EX &&
                   (regHit(hz.WriteReg_EX, hz.Rs_ID) ||
                    (hz.UsesRt_ID && regHit(hz.WriteReg_EX, hz.Rt_ID)));
        mduStall = hz.MduOp_ID && (mduBusy || hz.MduStart_EX);
        stall    = loadUse || mduStall;
    end

    // A taken branch squashes the ID instruction, so it outranks any stall.
    always_comb begin
        action = CTRL_RUN;
        if (!rst_n) begin
            action = CTRL_RUN;
        end else if (hz.BranchTaken_EX) begin
            action = CTRL_FLUSH;
        end else if (stall) begin
            action = CTRL_STALL;
        end
    end

    always_comb begin
        hz.PCWrite    = 1'b1;
        hz.IFID_Write = 1'b1;
        hz.IFID_Flush = 1'b0;
        hz.IDEX_Flush = 1'b0;
        case (action)
            CTRL_FLUSH: begin
                hz.IFID_Flush = 1'b1;
                hz.IDEX_Flush = 1'b1;
            end
            CTRL_STALL: begin
                hz.PCWrite    = 1'b0;
                hz.IFID_Write = 1'b0;
                hz.IDEX_Flush = 1'b1;
            end
            default: begin
                hz.PCWrite    = 1'b1;
                hz.IFID_Write = 1'b1;
            end
        endcase
    end

    assign hz.MduBusy = mduBusy;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Counters wrap naturally; stalls hidden under a flush are not counted as stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (stall && !hz.BranchTaken_EX) begin
                StallCycles <= StallCycles + CNT_ONE;
            end
            if (hz.BranchTaken_EX) begin
                FlushCount <= FlushCount + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: expectations queued at drive time, popped when sampled.
module tb_hazard_stall_unit;
    import hazard_pkg::*;

    localparam int LAT   = 4;
    localparam int CNT_W = 32;

    logic clk;
    logic rst_n;

    hazard_stall_unit_if hz ();

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] StallCycles;
    logic [CNT_W-1:0] FlushCount;
`endif

    hazard_stall_unit #(
        .MDU_LATENCY (LAT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz.slave)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .StallCycles (StallCycles),
        .FlushCount  (FlushCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Expected/observed vector: {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, MduBusy}
    logic [4:0] sbQ[$];
    logic [4:0] exp5;
    logic [4:0] obs5;
    int         modelCnt   = 0;
    int         modelStall = 0;
    int         modelFlush = 0;

    function automatic logic modelStallNow();
        logic lu;
        logic ms;
        lu = hz.MemRead_EX && (hz.WriteReg_EX != 5'd0) &&
             ((hz.WriteReg_EX == hz.Rs_ID) || (hz.UsesRt_ID && hz.WriteReg_EX == hz.Rt_ID));
        ms = hz.MduOp_ID && ((modelCnt != 0) || hz.MduStart_EX);
        return lu || ms;
    endfunction

    function automatic logic [4:0] modelExpect();
        logic busy;
        busy = (modelCnt != 0);
        if (!rst_n)                 return {4'b1100, busy};
        else if (hz.BranchTaken_EX) return {4'b1111, busy};
        else if (modelStallNow())   return {4'b0001, busy};
        else                        return {4'b1100, busy};
    endfunction

    function automatic logic [4:0] dutObs();
        return {hz.PCWrite, hz.IFID_Write, hz.IFID_Flush, hz.IDEX_Flush, hz.MduBusy};
    endfunction

    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                                 input logic mduOp, input logic memRead, input logic [4:0] wr,
                                 input logic start, input logic br);
        hz.Rs_ID          = rs;
        hz.Rt_ID          = rt;
        hz.UsesRt_ID      = usesRt;
        hz.MduOp_ID       = mduOp;
        hz.MemRead_EX     = memRead;
        hz.WriteReg_EX    = wr;
        hz.MduStart_EX    = start;
        hz.BranchTaken_EX = br;
        sbQ.push_back(modelExpect());
    endtask

    // Advance one clock edge, updating the reference counter model from the inputs at that edge.
    task automatic advanceClock();
        logic st;
        st = modelStallNow();
        @(posedge clk);
        if (!rst_n) begin
            modelCnt = 0; modelStall = 0; modelFlush = 0;
        end else begin
            if (hz.BranchTaken_EX) modelFlush++;
            else if (st)           modelStall++;
            if (hz.MduStart_EX)    modelCnt = LAT;
            else if (modelCnt != 0) modelCnt--;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        applyStimulus(5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        #2;
        exp5 = sbQ.pop_front(); obs5 = dutObs(); compared++;
        if (obs5 !== exp5) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", obs5, exp5);
        end
        advanceClock();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #2;
        exp5 = sbQ.pop_front(); obs5 = dutObs(); compared++;
        if (obs5 !== exp5 || obs5 !== 5'b11000) begin
            mismatched++;
            $display("[TB] FAIL reset_counter_held: got %b expected %b", obs5, exp5);
        end
        rst_n = 1'b1;
        advanceClock();
    endtask

    task automatic test_load_use();
        // Stall for exactly one cycle, then the load has moved on to MEM.
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        #2;
        exp5 = sbQ.pop_front(); obs5 = dutObs(); compared++;
        if (obs5 !== exp5 || obs5 !== 5'b00010) begin
            mismatched++;
            $display("[TB] FAIL load_use_rs: got %b expected %b", obs5, exp5);
        end
        advanceClock();
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0);
        #2;
        exp5 = sbQ.pop_front(); obs5 = dutObs(); compared++;
        if (obs5 !== exp5 || obs5 !== 5'b11000) begin
            mismatched++;
            $display("[TB] FAIL load_use_release: got %b expected %b", obs5, exp5);
        end
        advanceClock();
        applyStimulus(5'd3, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
        #2;
        exp5 = sbQ.pop_front(); obs5 = dutObs(); compared++;
        if (obs5 !== exp5) begin
            mismatched++;
            $display("[TB] FAIL load_use_rt: got %b expected %b", obs5, exp5);
        end
        advanceClock();
    endtask

    task automatic test_no_stall();
        logic [4:0] rsTab[3]     = '{5'd0, 5'd0, 5'd3};
        logic [4:0] rtTab[3]     = '{5'd0, 5'd9, 5'd4};
        logic       usesTab[3]   = '{1'b1, 1'b0, 1'b1};
        logic [4:0] wrTab[3]     = '{5'd0, 5'd9, 5'd9};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(rsTab[i], rtTab[i], usesTab[i], 1'b0, 1'b1, wrTab[i], 1'b0, 1'b0);
            #2;
            exp5 = sbQ.pop_front(); obs5 = dutObs(); compared++;
            if (obs5 !== exp5 || obs5 !== 5'b11000) begin
                mismatched++;
                $display("[TB] FAIL no_stall_%0d: got %b expected %b", i, obs5, exp5);
            end
            advanceClock();
        end
    endtask

    task automatic test_branch_priority();
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1);
        #2;
        exp5 = sbQ.pop_front(); obs5 = dutObs(); compared++;
        if (obs5 !== exp5 || obs5 !== 5'b11110) begin
            mismatched++;
            $display("[TB] FAIL branch_over_load_use: got %b expected %b", obs5, exp5);
        end
        advanceClock();
        // Mult/div issuing alongside a taken branch must still load the busy counter.
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        #2;
        exp5 = sbQ.pop_front(); obs5 = dutObs(); compared++;
        if (obs5 !== exp5) begin
            mismatched++;
            $display("[TB] FAIL branch_with_mdu_start: got %b expected %b", obs5, exp5);
        end
        advanceClock();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        #2;
        exp5 = sbQ.pop_front(); obs5 = dutObs(); compared++;
        if (obs5 !== exp5 || obs5 !== 5'b00011) begin
            mismatched++;
            $display("[TB] FAIL mdu_loaded_under_branch: got %b expected %b", obs5, exp5);
        end
        while (modelCnt != 0) advanceClock();
        advanceClock();
    endtask

    task automatic test_mdu_stall();
        int stalls = 0;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        for (int c = 0; c < 7; c++) begin
            #2;
            exp5 = sbQ.pop_front(); obs5 = dutObs(); compared++;
            if (obs5 !== exp5) begin
                mismatched++;
                $display("[TB] FAIL mdu_cycle_%0d: got %b expected %b", c, obs5, exp5);
            end
            if (obs5[1]) stalls++;
            advanceClock();
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        end
        void'(sbQ.pop_front());
        compared++;
        if (stalls !== LAT + 1) begin
            mismatched++;
            $display("[TB] FAIL mdu_stall_length: got %0d expected %0d", stalls, LAT + 1);
        end
    endtask

    task automatic test_reset_midop();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        void'(sbQ.pop_front());
        advanceClock();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        void'(sbQ.pop_front());
        advanceClock();
        rst_n    = 1'b0;
        modelCnt = 0;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        exp5 = sbQ.pop_front(); obs5 = dutObs(); compared++;
        if (obs5 !== exp5 || obs5[0] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL async_reset_busy: got %b expected %b", obs5, exp5);
        end
        advanceClock();
        rst_n = 1'b1;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        #2;
        exp5 = sbQ.pop_front(); obs5 = dutObs(); compared++;
        if (obs5 !== exp5 || obs5 !== 5'b11000) begin
            mismatched++;
            $display("[TB] FAIL after_reset_no_stall: got %b expected %b", obs5, exp5);
        end
        advanceClock();
    endtask

    task automatic test_back_to_back();
        logic [4:0] rs, rt, wr;
        for (int c = 0; c < 60; c++) begin
            rs = 5'($urandom_range(0, 3));
            rt = 5'($urandom_range(0, 3));
            wr = 5'($urandom_range(0, 3));
            applyStimulus(rs, rt, 1'($urandom), 1'($urandom), 1'($urandom), wr,
                          ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
            #2;
            exp5 = sbQ.pop_front(); obs5 = dutObs(); compared++;
            if (obs5 !== exp5) begin
                mismatched++;
                $display("[TB] FAIL random_%0d: got %b expected %b", c, obs5, exp5);
            end
            advanceClock();
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_counters();
        rst_n = 1'b0;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        void'(sbQ.pop_front());
        advanceClock();
        rst_n = 1'b1;
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        void'(sbQ.pop_front());
        advanceClock();
        applyStimulus(5'd2, 5'd8, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        void'(sbQ.pop_front());
        advanceClock();
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1);
        void'(sbQ.pop_front());
        advanceClock();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        void'(sbQ.pop_front());
        compared++;
        if (StallCycles !== 32'd2) begin
            mismatched++;
            $display("[TB] FAIL perf_stall_cycles: got %0d expected 2", StallCycles);
        end
        compared++;
        if (FlushCount !== 32'd1) begin
            mismatched++;
            $display("[TB] FAIL perf_flush_count: got %0d expected 1", FlushCount);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        void'(sbQ.pop_front());
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch_priority();
        test_mdu_stall();
        test_reset_midop();
        test_back_to_back();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
